// File: rtl/vga_timing_pkg.sv
// VGA 640x480 raster timing constants shared by the sync generator and the
// pixel-colour block, plus a small window-decode helper.
package vga_timing_pkg;

   localparam int COORD_W     = 10;

   localparam int H_TOTAL     = 800;
   localparam int H_SYNC      = 96;
   localparam int H_ACT_START = 144;
   localparam int H_ACT_END   = 784;

   localparam int V_TOTAL     = 521;
   localparam int V_SYNC      = 2;
   localparam int V_ACT_START = 31;
   localparam int V_ACT_END   = 511;

   // Half-open interval test: lo <= v < hi
   function automatic logic in_range(input logic [COORD_W-1:0] v,
                                     input logic [COORD_W-1:0] lo,
                                     input logic [COORD_W-1:0] hi);
      return (v >= lo) && (v < hi);
   endfunction

endpackage

// File: rtl/vga_sync_gen_pix_en_gen.sv
// Pixel-rate divider. adv is the combinational "strobe next edge" indication
// used by the raster counters; pix_en is the registered strobe that is high
// in the same cycle the counters show their new value.
module pix_en_gen #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   output logic adv,
   output logic pix_en
);

   localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pix_en_q, pix_en_d;

   // Divider count 0..CLK_DIV-1 and the next pixel strobe
   always_comb begin
      adv      = (cnt_q == CNT_MAX);
      cnt_d    = adv ? '0 : cnt_q + 1'b1;
      pix_en_d = adv;
   end

   // Divider and strobe registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         pix_en_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         pix_en_q <= pix_en_d;
      end
   end

   assign pix_en = pix_en_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: hc/vc counters, active-low syncs, videoen and
// line/frame ticks. Every output is registered and decoded from the
// next-state counters so it lines up with the hc/vc shown in the same cycle.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV     = 4,
   parameter int H_TOTAL     = vga_timing_pkg::H_TOTAL,
   parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
   parameter int H_ACT_START = vga_timing_pkg::H_ACT_START,
   parameter int H_ACT_END   = vga_timing_pkg::H_ACT_END,
   parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL,
   parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
   parameter int V_ACT_START = vga_timing_pkg::V_ACT_START,
   parameter int V_ACT_END   = vga_timing_pkg::V_ACT_END
) (
   input  logic               clk,
   input  logic               rst,
   output logic [COORD_W-1:0] hc,
   output logic [COORD_W-1:0] vc,
   output logic               hsync,
   output logic               vsync,
   output logic               videoen,
   output logic               pix_en,
   output logic               line_tick,
   output logic               frame_tick
);

   localparam logic [COORD_W-1:0] HC_MAX = COORD_W'(H_TOTAL - 1);
   localparam logic [COORD_W-1:0] VC_MAX = COORD_W'(V_TOTAL - 1);
   localparam logic [COORD_W-1:0] HS_END = COORD_W'(H_SYNC);
   localparam logic [COORD_W-1:0] VS_END = COORD_W'(V_SYNC);
   localparam logic [COORD_W-1:0] HA_LO  = COORD_W'(H_ACT_START);
   localparam logic [COORD_W-1:0] HA_HI  = COORD_W'(H_ACT_END);
   localparam logic [COORD_W-1:0] VA_LO  = COORD_W'(V_ACT_START);
   localparam logic [COORD_W-1:0] VA_HI  = COORD_W'(V_ACT_END);

   logic               adv;
   logic [COORD_W-1:0] hc_q, hc_d, vc_q, vc_d;
   logic               hsync_q, hsync_d, vsync_q, vsync_d;
   logic               videoen_q, videoen_d;
   logic               line_tick_q, line_tick_d, frame_tick_q, frame_tick_d;

   pix_en_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_pix_en_gen (
      .clk    (clk),
      .rst    (rst),
      .adv    (adv),
      .pix_en (pix_en)
   );

   // Next raster position, wrap ticks and output decode of that position
   always_comb begin
      hc_d         = hc_q;
      vc_d         = vc_q;
      line_tick_d  = 1'b0;
      frame_tick_d = 1'b0;
      if (adv) begin
         if (hc_q == HC_MAX) begin
            hc_d        = '0;
            line_tick_d = 1'b1;
            if (vc_q == VC_MAX) begin
               vc_d         = '0;
               frame_tick_d = 1'b1;
            end else begin
               vc_d = vc_q + 1'b1;
            end
         end else begin
            hc_d = hc_q + 1'b1;
         end
      end
      hsync_d   = (hc_d >= HS_END);
      vsync_d   = (vc_d >= VS_END);
      videoen_d = in_range(hc_d, HA_LO, HA_HI) && in_range(vc_d, VA_LO, VA_HI);
   end

   // Raster state and output registers; reset restarts at (0,0) with no ticks
   always_ff @(posedge clk) begin
      if (rst) begin
         hc_q         <= '0;
         vc_q         <= '0;
         hsync_q      <= 1'b0;
         vsync_q      <= 1'b0;
         videoen_q    <= 1'b0;
         line_tick_q  <= 1'b0;
         frame_tick_q <= 1'b0;
      end else begin
         hc_q         <= hc_d;
         vc_q         <= vc_d;
         hsync_q      <= hsync_d;
         vsync_q      <= vsync_d;
         videoen_q    <= videoen_d;
         line_tick_q  <= line_tick_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign hc         = hc_q;
   assign vc         = vc_q;
   assign hsync      = hsync_q;
   assign vsync      = vsync_q;
   assign videoen    = videoen_q;
   assign line_tick  = line_tick_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a full-timing instance (CLK_DIV=4) and a
// CLK_DIV=1 instance with a short 12-line frame, each compared cycle by
// cycle against a closed-form model of time since reset release.
module tb_vga_sync_gen;

   typedef struct packed {
      logic [9:0] hc;
      logic [9:0] vc;
      logic       hs;
      logic       vs;
      logic       ven;
      logic       pe;
      logic       lt;
      logic       ft;
   } obs_t;

   logic clk = 1'b0;
   logic rst_a, rst_b;

   logic [9:0] hc_a, vc_a, hc_b, vc_b;
   logic hs_a, vs_a, ven_a, pe_a, lt_a, ft_a;
   logic hs_b, vs_b, ven_b, pe_b, lt_b, ft_b;

   int n_chk = 0;
   int n_err = 0;

   int t_a = 0, t_b = 0;
   obs_t q_a[$];
   obs_t q_b[$];
   obs_t cur_a, cur_b;

   // measurement state
   int   fall_a = -1;
   int   ltm_a  = 0;
   int   ltm_b  = 0;
   int   ftm_b  = 0;
   int   vcnt_b = 0;
   logic hsp_a = 1'b0, vsp_a = 1'b0, vsp_b = 1'b0, venp_b = 1'b0;

   always #5 clk = ~clk;

   vga_sync_gen #(
      .CLK_DIV (4)
   ) dut_a (
      .clk (clk), .rst (rst_a), .hc (hc_a), .vc (vc_a),
      .hsync (hs_a), .vsync (vs_a), .videoen (ven_a), .pix_en (pe_a),
      .line_tick (lt_a), .frame_tick (ft_a)
   );

   vga_sync_gen #(
      .CLK_DIV (1), .V_TOTAL (12), .V_SYNC (2), .V_ACT_START (3), .V_ACT_END (10)
   ) dut_b (
      .clk (clk), .rst (rst_b), .hc (hc_b), .vc (vc_b),
      .hsync (hs_b), .vsync (vs_b), .videoen (ven_b), .pix_en (pe_b),
      .line_tick (lt_b), .frame_tick (ft_b)
   );

   // Expected outputs t clocks after reset release (t=0: reset state)
   function automatic obs_t model(int t, int div, int vt, int vsy, int vas, int vae);
      obs_t o;
      int s, h, v;
      o = '0;
      if (t > 0) begin
         s     = t / div;
         h     = s % 800;
         v     = (s / 800) % vt;
         o.hc  = 10'(h);
         o.vc  = 10'(v);
         o.pe  = ((t % div) == 0);
         o.lt  = o.pe && (h == 0);
         o.ft  = o.lt && (v == 0);
         o.hs  = (h >= 96);
         o.vs  = (v >= vsy);
         o.ven = (h >= 144) && (h < 784) && (v >= vas) && (v < vae);
      end
      return o;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      logic ra, rb;
      obs_t ea, eb;
      ra  = rst_a;
      rb  = rst_b;
      t_a = ra ? 0 : t_a + 1;
      t_b = rb ? 0 : t_b + 1;
      q_a.push_back(model(t_a, 4, 521, 2, 31, 511));
      q_b.push_back(model(t_b, 1, 12, 2, 3, 10));
      @(posedge clk);
      #1;
      cur_a = {hc_a, vc_a, hs_a, vs_a, ven_a, pe_a, lt_a, ft_a};
      cur_b = {hc_b, vc_b, hs_b, vs_b, ven_b, pe_b, lt_b, ft_b};
      ea = q_a.pop_front();
      eb = q_b.pop_front();
      chk("cycle_a", cur_a, ea);
      chk("cycle_b", cur_b, eb);

      if (ra) begin
         fall_a = -1;
         ltm_a  = 0;
      end else begin
         if (hsp_a && !cur_a.hs) begin
            if (fall_a >= 0) chk("hsync_period", t_a - fall_a, 3200);
            fall_a = t_a;
         end
         if (!hsp_a && cur_a.hs && fall_a >= 0) chk("hsync_low", t_a - fall_a, 384);
         if (cur_a.lt) begin
            chk("line_period_a", t_a - ltm_a, 3200);
            chk("line_hc_a", cur_a.hc, 0);
            ltm_a = t_a;
         end
         if (!vsp_a && cur_a.vs) chk("vsync_low_a", t_a, 6400);
      end
      hsp_a = cur_a.hs;
      vsp_a = cur_a.vs;

      if (rb) begin
         ltm_b  = 0;
         ftm_b  = 0;
         vcnt_b = 0;
      end else begin
         if (cur_b.ven && cur_b.pe) vcnt_b++;
         if (!venp_b && cur_b.ven) chk("ven_rise_hc", cur_b.hc, 144);
         if (venp_b && !cur_b.ven && cur_b.vc >= 3 && cur_b.vc < 10)
            chk("ven_fall_hc", cur_b.hc, 784);
         if (cur_b.lt) begin
            chk("line_period_b", t_b - ltm_b, 800);
            ltm_b = t_b;
         end
         if (!vsp_b && cur_b.vs) chk("vsync_low_b", t_b - ftm_b, 1600);
         if (cur_b.ft) begin
            chk("frame_period_b", t_b - ftm_b, 9600);
            chk("frame_videoen_cnt", vcnt_b, 4480);
            chk("frame_both_ticks", {cur_b.lt, cur_b.hc, cur_b.vc}, {1'b1, 20'd0});
            ftm_b  = t_b;
            vcnt_b = 0;
         end
      end
      vsp_b  = cur_b.vs;
      venp_b = cur_b.ven;
   endtask

   initial begin
      int n;
      rst_a = 1'b1;
      rst_b = 1'b1;
      repeat (10) tick();
      chk("reset_state_a", cur_a, 0);
      chk("reset_state_b", cur_b, 0);

      // release: first strobe 4 clks later on dut_a with hc stepping to 1
      rst_a = 1'b0;
      rst_b = 1'b0;
      repeat (3) tick();
      chk("pre_strobe_a", {cur_a.pe, cur_a.hc}, {1'b0, 10'd0});
      tick();
      chk("first_strobe_a", {cur_a.pe, cur_a.hc}, {1'b1, 10'd1});
      chk("div1_held_b", cur_b.pe, 1);

      // several lines of dut_a and two full frames of dut_b
      repeat (20000) tick();

      // mid-line reset of dut_a at hc=400
      n = 0;
      while (cur_a.hc != 10'd400 && n < 4000) begin
         tick();
         n++;
      end
      chk("wait_hc400_a", n < 4000, 1);
      rst_a = 1'b1;
      tick();
      rst_a = 1'b0;
      chk("mid_reset_a", cur_a, 0);

      // mid-frame reset of dut_b at hc=400, vc=6
      n = 0;
      while (!(cur_b.hc == 10'd400 && cur_b.vc == 10'd6) && n < 10000) begin
         tick();
         n++;
      end
      chk("wait_pos_b", n < 10000, 1);
      rst_b = 1'b1;
      tick();
      rst_b = 1'b0;
      chk("mid_reset_b", cur_b, 0);

      // a full frame of dut_b and further lines of dut_a after reset
      repeat (10000) tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
